// File: rtl/ctrl_rega_pkg.sv
// Shared encodings for the irrigation sequencer and users of the cont_cinco down-counter.
package ctrl_rega_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CARGA = 2'd1,
    REGA  = 2'd2,
    PAUSA = 2'd3
  } estado_t;

  localparam logic [2:0] CNT_MAX = 3'd5;

  // A 5-to-0 counter can never legally show 6 or 7.
  function automatic logic cnt_invalido(input logic [2:0] cnt);
    return (cnt > CNT_MAX);
  endfunction

endpackage

// File: rtl/ctrl_rega_nivel_tanque.sv
// Tank fill pump hysteresis, low-level alarm and detection of the impossible sensor pair.
module nivel_tanque (
  input  logic clk,
  input  logic rst,
  input  logic nivel_min,
  input  logic nivel_max,
  input  logic erro,
  output logic bomba,
  output logic alarme,
  output logic falha
);

  logic bomba_r;
  logic alarme_r;

  assign falha  = nivel_max & ~nivel_min;
  assign bomba  = bomba_r;
  assign alarme = alarme_r;

  // Pump: set below minimum, cleared when full, held in between; any fault shuts it off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bomba_r  <= 1'b0;
      alarme_r <= 1'b0;
    end else begin
      alarme_r <= ~nivel_min;
      if (falha | erro) begin
        bomba_r <= 1'b0;
      end else if (nivel_max) begin
        bomba_r <= 1'b0;
      end else if (~nivel_min) begin
        bomba_r <= 1'b1;
      end else begin
        bomba_r <= bomba_r;
      end
    end
  end

endmodule

// File: rtl/ctrl_rega.sv
// Irrigation sequencer: presets cont_cinco, times watering from its count, drives valves and alarms.
module ctrl_rega
  import ctrl_rega_pkg::*;
#(
  parameter int PAUSA_CICLOS = 3
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Seco,
  input  logic       Chuva,
  input  logic       TempAlta,
  input  logic       NivelMin,
  input  logic       NivelMax,
  input  logic [2:0] Cnt,
  output logic       Pos5,
  output logic       Pos0,
  output logic       Aspersor,
  output logic       Gotejo,
  output logic       Bomba,
  output logic       Alarme,
  output logic       Erro
);

  localparam logic [2:0] PAUSA_INI = 3'(PAUSA_CICLOS - 1);

  estado_t    estado_r;
  estado_t    estado_nxt_s;
  logic [2:0] pausa_r;
  logic       modo_r;
  logic       modo_nxt_s;
  logic       pos5_r;
  logic       pos0_r;
  logic       aspersor_r;
  logic       gotejo_r;
  logic       erro_r;
  logic       cnt_falha_s;
  logic       tanque_falha_s;
  logic       erro_set_s;
  logic       fim_s;

  assign Pos5     = pos5_r;
  assign Pos0     = pos0_r;
  assign Aspersor = aspersor_r;
  assign Gotejo   = gotejo_r;
  assign Erro     = erro_r;

  assign cnt_falha_s = (estado_r == REGA) & cnt_invalido(Cnt);
  assign erro_set_s  = erro_r | cnt_falha_s | tanque_falha_s;
  // Cnt==1 is the last watering cycle: the counter lands on 0 on the same edge we leave REGA.
  assign fim_s       = (Cnt <= 3'd1) | Chuva | ~NivelMin | erro_set_s;

  nivel_tanque u_nivel_tanque (
    .clk       (Clk),
    .rst       (Rst),
    .nivel_min (NivelMin),
    .nivel_max (NivelMax),
    .erro      (erro_r | cnt_falha_s),
    .bomba     (Bomba),
    .alarme    (Alarme),
    .falha     (tanque_falha_s)
  );

  // Next-state and watering-mode selection.
  always_comb begin
    estado_nxt_s = estado_r;
    if (estado_r == CARGA) begin
      modo_nxt_s = TempAlta;
    end else begin
      modo_nxt_s = modo_r;
    end
    case (estado_r)
      IDLE: begin
        if (Seco & ~Chuva & NivelMin & ~erro_set_s) begin
          estado_nxt_s = CARGA;
        end else begin
          estado_nxt_s = IDLE;
        end
      end
      CARGA: begin
        if (erro_set_s) begin
          estado_nxt_s = PAUSA;
        end else begin
          estado_nxt_s = REGA;
        end
      end
      REGA: begin
        if (fim_s) begin
          estado_nxt_s = PAUSA;
        end else begin
          estado_nxt_s = REGA;
        end
      end
      PAUSA: begin
        if (pausa_r == 3'd0) begin
          estado_nxt_s = IDLE;
        end else begin
          estado_nxt_s = PAUSA;
        end
      end
      default: estado_nxt_s = IDLE;
    endcase
  end

  // Sequencer state with outputs decoded from the next state so they are registered.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      estado_r   <= IDLE;
      pausa_r    <= 3'd0;
      modo_r     <= 1'b0;
      pos5_r     <= 1'b0;
      pos0_r     <= 1'b1;
      aspersor_r <= 1'b0;
      gotejo_r   <= 1'b0;
    end else begin
      estado_r   <= estado_nxt_s;
      modo_r     <= modo_nxt_s;
      pos5_r     <= (estado_nxt_s == CARGA);
      pos0_r     <= (estado_nxt_s == IDLE) | (estado_nxt_s == PAUSA);
      aspersor_r <= (estado_nxt_s == REGA) & modo_nxt_s;
      gotejo_r   <= (estado_nxt_s == REGA) & ~modo_nxt_s;
      if ((estado_nxt_s == PAUSA) && (estado_r != PAUSA)) begin
        pausa_r <= PAUSA_INI;
      end else if ((estado_r == PAUSA) && (pausa_r != 3'd0)) begin
        pausa_r <= pausa_r - 3'd1;
      end else begin
        pausa_r <= pausa_r;
      end
    end
  end

  // Sticky fault flag, cleared only by reset.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      erro_r <= 1'b0;
    end else begin
      erro_r <= erro_set_s;
    end
  end

endmodule

// File: tb/tb_ctrl_rega.sv
// Directed bench for ctrl_rega with a behavioural cont_cinco model closing the loop.
module tb_ctrl_rega;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       Seco = 1'b0, Chuva = 1'b0, TempAlta = 1'b0, NivelMin = 1'b1, NivelMax = 1'b0;
  logic [2:0] Cnt;
  logic       Pos5, Pos0, Aspersor, Gotejo, Bomba, Alarme, Erro;
  logic [2:0] cnt_mod = 3'd0;
  logic       force_en = 1'b0;
  logic [2:0] force_val = 3'd0;
  logic [6:0] o;
  int         checks = 0;
  int         failures = 0;

  always #5 Clk = ~Clk;

  assign Cnt = force_en ? force_val : cnt_mod;
  assign o   = {Pos5, Pos0, Aspersor, Gotejo, Bomba, Alarme, Erro};

  // cont_cinco model: Pos0 clears, Pos5 presets to 5, otherwise count down to 0.
  always @(posedge Clk) begin
    if (Pos0) cnt_mod <= 3'd0;
    else if (Pos5) cnt_mod <= 3'd5;
    else if (cnt_mod != 3'd0) cnt_mod <= cnt_mod - 3'd1;
  end

  ctrl_rega #(.PAUSA_CICLOS(3)) dut (
    .Clk(Clk), .Rst(Rst), .Seco(Seco), .Chuva(Chuva), .TempAlta(TempAlta),
    .NivelMin(NivelMin), .NivelMax(NivelMax), .Cnt(Cnt),
    .Pos5(Pos5), .Pos0(Pos0), .Aspersor(Aspersor), .Gotejo(Gotejo),
    .Bomba(Bomba), .Alarme(Alarme), .Erro(Erro)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Reset with the given sensor inputs applied, released on a falling edge.
  task automatic start(input logic seco, input logic temp);
    @(negedge Clk);
    Rst = 1'b1; Seco = seco; TempAlta = temp; Chuva = 1'b0;
    NivelMin = 1'b1; NivelMax = 1'b0; force_en = 1'b0;
    @(posedge Clk);
    @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  task automatic test_reset();
    start(1'b0, 1'b0);
    #1;
    checks++;
    if (o !== 7'b0100000) begin failures++; $display("FAIL reset_outs got=%b exp=%b", o, 7'b0100000); end
    tick();
    checks++;
    if (o !== 7'b0100000) begin failures++; $display("FAIL idle_dry got=%b exp=%b", o, 7'b0100000); end
  endtask

  task automatic test_nominal_drip();
    start(1'b1, 1'b0);
    tick();
    checks++;
    if (o !== 7'b1000000) begin failures++; $display("FAIL drip_carga got=%b exp=%b", o, 7'b1000000); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (o !== 7'b0001000 || cnt_mod !== 3'(5 - i)) begin
        failures++;
        $display("FAIL drip_rega%0d got=%b cnt=%0d exp=%b cnt=%0d", i, o, cnt_mod, 7'b0001000, 5 - i);
      end
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (o !== 7'b0100000) begin failures++; $display("FAIL drip_pausa%0d got=%b exp=%b", i, o, 7'b0100000); end
    end
    tick();
    checks++;
    if (o !== 7'b1000000) begin failures++; $display("FAIL drip_restart got=%b exp=%b", o, 7'b1000000); end
  endtask

  task automatic test_sprinkler_frozen();
    start(1'b1, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin @(negedge Clk); TempAlta = 1'b0; end
      tick();
      checks++;
      if (o !== 7'b0010000) begin failures++; $display("FAIL asp_rega%0d got=%b exp=%b", i, o, 7'b0010000); end
    end
    tick();
    checks++;
    if (o !== 7'b0100000) begin failures++; $display("FAIL asp_end got=%b exp=%b", o, 7'b0100000); end
  endtask

  task automatic test_rain_abort();
    start(1'b1, 1'b0);
    tick(); tick(); tick(); tick();
    checks++;
    if (cnt_mod !== 3'd3 || o !== 7'b0001000) begin
      failures++; $display("FAIL rain_pre got=%b cnt=%0d exp=%b cnt=3", o, cnt_mod, 7'b0001000);
    end
    @(negedge Clk); Chuva = 1'b1;
    tick();
    checks++;
    if (o !== 7'b0100000) begin failures++; $display("FAIL rain_abort got=%b exp=%b", o, 7'b0100000); end
    tick();
    checks++;
    if (cnt_mod !== 3'd0) begin failures++; $display("FAIL rain_cnt got=%0d exp=0", cnt_mod); end
  endtask

  task automatic test_tank_low();
    start(1'b1, 1'b0);
    tick(); tick(); tick();
    @(negedge Clk); NivelMin = 1'b0;
    tick();
    checks++;
    if (o !== 7'b0100110) begin failures++; $display("FAIL low_abort got=%b exp=%b", o, 7'b0100110); end
    @(negedge Clk); NivelMin = 1'b1;
    tick();
    checks++;
    if (o !== 7'b0100100) begin failures++; $display("FAIL low_hold got=%b exp=%b", o, 7'b0100100); end
    @(negedge Clk); NivelMax = 1'b1;
    tick();
    checks++;
    if (o !== 7'b0100000) begin failures++; $display("FAIL low_full got=%b exp=%b", o, 7'b0100000); end
  endtask

  task automatic test_cnt_fault();
    start(1'b1, 1'b0);
    tick(); tick(); tick();
    @(negedge Clk); force_en = 1'b1; force_val = 3'd7;
    tick();
    checks++;
    if (o !== 7'b0100001) begin failures++; $display("FAIL cnt7_abort got=%b exp=%b", o, 7'b0100001); end
    @(negedge Clk); force_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (o !== 7'b0100001) begin failures++; $display("FAIL cnt7_sticky%0d got=%b exp=%b", i, o, 7'b0100001); end
    end
  endtask

  task automatic test_tank_fault();
    start(1'b0, 1'b0);
    @(negedge Clk); NivelMin = 1'b0;
    tick();
    checks++;
    if (o !== 7'b0100110) begin failures++; $display("FAIL tf_fill got=%b exp=%b", o, 7'b0100110); end
    @(negedge Clk); NivelMax = 1'b1;
    tick();
    checks++;
    if (o !== 7'b0100011) begin failures++; $display("FAIL tf_impossible got=%b exp=%b", o, 7'b0100011); end
    @(negedge Clk); NivelMax = 1'b0;
    tick();
    checks++;
    if (o !== 7'b0100011) begin failures++; $display("FAIL tf_pump_off got=%b exp=%b", o, 7'b0100011); end
    @(negedge Clk); NivelMin = 1'b1; Seco = 1'b1;
    tick(); tick();
    checks++;
    if (o !== 7'b0100001) begin failures++; $display("FAIL tf_idle got=%b exp=%b", o, 7'b0100001); end
  endtask

  task automatic test_async_reset();
    start(1'b1, 1'b1);
    tick(); tick(); tick();
    checks++;
    if (o !== 7'b0010000) begin failures++; $display("FAIL ar_pre got=%b exp=%b", o, 7'b0010000); end
    #2 Rst = 1'b1;
    #1;
    checks++;
    if (o !== 7'b0100000) begin failures++; $display("FAIL ar_immediate got=%b exp=%b", o, 7'b0100000); end
    @(negedge Clk); Rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal_drip();
    test_sprinkler_frozen();
    test_rain_abort();
    test_tank_low();
    test_cnt_fault();
    test_tank_fault();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
